mem_stage: RTL and testbench

- Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back.
- Latches the execute-stage result and waits for the data-SRAM `data_ok` response on loads and stores.
- Aligns and sign/zero-extends load data, then hands the completed instruction to write-back.
- Publishes forwarding and exception status back to the ID/EX stages, and discards stale SRAM responses after a pipeline flush.

---
 rtl/mem_stage_if.sv | 62 ++++++
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM, MEM->WB, data-SRAM response and forwarding signals of the memory stage
//   slave  : seen from mem_stage (EX/WB/SRAM-side inputs, MEM outputs)
//   master : seen from the surrounding pipeline
//   ex_to_mem_valid/mem_allowin     EX->MEM handshake
//   in_*                            instruction fields latched from EX
//   data_sram_data_ok/rdata         SRAM response
//   flush, wb_allowin               control from WB
//   mem_to_wb_valid/out_*           instruction handed to WB
//   mem_to_ex_bus                   {excep, ertn} status for EX
//   mem_fwd_*                       forwarding/stall info for ID
interface mem_stage_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic              ex_to_mem_valid;
    logic              mem_allowin;
    logic [PC_W-1:0]   in_pc;
    logic              in_rf_we;
    logic [4:0]        in_rf_waddr;
    logic [DATA_W-1:0] in_alu_result;
    logic              in_mem_req;
    logic              in_res_from_mem;
    logic              in_ld_b;
    logic              in_ld_h;
    logic              in_ld_u;
    logic              in_excep_en;
    logic              in_ertn;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              flush;
    logic              wb_allowin;
    logic              mem_to_wb_valid;
    logic [PC_W-1:0]   out_pc;
    logic              out_rf_we;
    logic [4:0]        out_rf_waddr;
    logic [DATA_W-1:0] out_rf_wdata;
    logic              out_excep_en;
    logic              out_ertn;
    logic [1:0]        mem_to_ex_bus;
    logic              mem_fwd_we;
    logic [4:0]        mem_fwd_waddr;
    logic [DATA_W-1:0] mem_fwd_wdata;
    logic              mem_fwd_busy;

    modport slave (
        input  ex_to_mem_valid, in_pc, in_rf_we, in_rf_waddr, in_alu_result, in_mem_req,
               in_res_from_mem, in_ld_b, in_ld_h, in_ld_u, in_excep_en, in_ertn,
               data_sram_data_ok, data_sram_rdata, flush, wb_allowin,
        output mem_allowin, mem_to_wb_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata,
               out_excep_en, out_ertn, mem_to_ex_bus, mem_fwd_we, mem_fwd_waddr,
               mem_fwd_wdata, mem_fwd_busy
    );

    modport master (
        output ex_to_mem_valid, in_pc, in_rf_we, in_rf_waddr, in_alu_result, in_mem_req,
               in_res_from_mem, in_ld_b, in_ld_h, in_ld_u, in_excep_en, in_ertn,
               data_sram_data_ok, data_sram_rdata, flush, wb_allowin,
        input  mem_allowin, mem_to_wb_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata,
               out_excep_en, out_ertn, mem_to_ex_bus, mem_fwd_we, mem_fwd_waddr,
               mem_fwd_wdata, mem_fwd_busy
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage (waits for data_ok, extends load data, hands off to WB)
//   clk     clock
//   resetn  synchronous active-low reset
//   bus     mem_stage_if.slave: EX/WB handshakes, SRAM response, forwarding outputs
//   Optional: define MEM_LOAD_FWD_EN to forward completed load data from MEM.
module mem_stage #(
    parameter int PC_W            = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic       clk,
    input logic       resetn,
    mem_stage_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    logic              valid, rf_we, mem_req, res_from_mem, ld_b, ld_h, ld_u, excep_en, ertn;
    logic              data_ok_seen;
    logic [PC_W-1:0]   pc;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] alu_result, rdata_buf;
    logic [CW-1:0]     cancel_cnt;
    logic              live_ok, drop, cancel_inc, ready_go, enter;
    logic [DATA_W-1:0] src, ld_data;
    logic [7:0]        byte_d;
    logic [15:0]       half_d;

    // a response belongs to the current instruction only once all stale ones are drained
    assign live_ok    = bus.data_sram_data_ok && cancel_cnt == '0;
    assign drop       = bus.data_sram_data_ok && cancel_cnt != '0;
    // the flushed instruction still owes a response unless it arrives this very cycle
    assign cancel_inc = bus.flush && valid && mem_req && !data_ok_seen && !live_ok;
    assign ready_go   = !mem_req || data_ok_seen || live_ok;
    assign bus.mem_allowin = !valid || (ready_go && bus.wb_allowin);
    assign enter      = bus.ex_to_mem_valid && bus.mem_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid        <= 1'b0;
            pc           <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            alu_result   <= '0;
            mem_req      <= 1'b0;
            res_from_mem <= 1'b0;
            ld_b         <= 1'b0;
            ld_h         <= 1'b0;
            ld_u         <= 1'b0;
            excep_en     <= 1'b0;
            ertn         <= 1'b0;
            data_ok_seen <= 1'b0;
            rdata_buf    <= '0;
            cancel_cnt   <= '0;
        end else begin
            if (bus.flush)
                valid <= 1'b0;
            else if (bus.mem_allowin)
                valid <= bus.ex_to_mem_valid;
            if (enter) begin
                pc           <= bus.in_pc;
                rf_we        <= bus.in_rf_we && !bus.in_excep_en;
                rf_waddr     <= bus.in_rf_waddr;
                alu_result   <= bus.in_alu_result;
                mem_req      <= bus.in_mem_req;
                res_from_mem <= bus.in_res_from_mem;
                ld_b         <= bus.in_ld_b;
                ld_h         <= bus.in_ld_h;
                ld_u         <= bus.in_ld_u;
                excep_en     <= bus.in_excep_en;
                ertn         <= bus.in_ertn;
                data_ok_seen <= 1'b0;
            end else if (valid && mem_req && !data_ok_seen && live_ok && !bus.wb_allowin) begin
                data_ok_seen <= 1'b1;
                rdata_buf    <= bus.data_sram_rdata;
            end
            if (cancel_inc && !drop && cancel_cnt != CMAX)
                cancel_cnt <= cancel_cnt + 1'b1;
            else if (drop && !cancel_inc)
                cancel_cnt <= cancel_cnt - 1'b1;
        end
    end

    cancel_sat: assert property (@(posedge clk) disable iff (!resetn) cancel_cnt != CMAX);

    always_comb begin
        src     = data_ok_seen ? rdata_buf : bus.data_sram_rdata;
        byte_d  = src[{alu_result[1:0], 3'b000} +: 8];
        half_d  = src[{alu_result[1], 4'b0000} +: 16];
        ld_data = ld_b ? {{(DATA_W-8){byte_d[7] && !ld_u}}, byte_d} :
                  ld_h ? {{(DATA_W-16){half_d[15] && !ld_u}}, half_d} : src;
    end

    assign bus.mem_to_wb_valid = valid && ready_go;
    assign bus.out_pc          = pc;
    assign bus.out_rf_we       = rf_we;
    assign bus.out_rf_waddr    = rf_waddr;
    assign bus.out_rf_wdata    = res_from_mem ? ld_data : alu_result;
    assign bus.out_excep_en    = excep_en;
    assign bus.out_ertn        = ertn;
    assign bus.mem_to_ex_bus   = {excep_en && valid, ertn && valid};
    assign bus.mem_fwd_we      = valid && rf_we;
    assign bus.mem_fwd_waddr   = rf_waddr;
`ifdef MEM_LOAD_FWD_EN
    assign bus.mem_fwd_wdata   = (res_from_mem && ready_go) ? ld_data : alu_result;
    assign bus.mem_fwd_busy    = valid && res_from_mem && !ready_go;
`else
    // loads forward from WB only
    assign bus.mem_fwd_wdata   = alu_result;
    assign bus.mem_fwd_busy    = valid && res_from_mem;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage against a transaction-level model
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.PC_W(32), .DATA_W(32)) bus();
    mem_stage #(.PC_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic        mreq, load, b, h, u, exc, ertn;
        logic [31:0] rdata;
        int          id;
    } ins_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } resp_t;

    int    checks = 0;
    int    failures = 0;
    int    next_id = 0;
    ins_t  ex_q[$];
    resp_t resp_q[$];
    ins_t  cur;
    bit    cur_v = 0;
    bit    cur_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_val(input ins_t i);
        logic [31:0] v;
        if (i.b) begin
            v = (i.rdata >> (8 * i.alu[1:0])) & 32'hFF;
            if (!i.u && v[7]) v = v | 32'hFFFFFF00;
        end else if (i.h) begin
            v = (i.rdata >> (16 * i.alu[1])) & 32'hFFFF;
            if (!i.u && v[15]) v = v | 32'hFFFF0000;
        end else v = i.rdata;
        return v;
    endfunction

    function automatic logic [31:0] wdata_of(input ins_t i);
        return i.load ? ld_val(i) : i.alu;
    endfunction

    // kind: 0 alu, 1 load, 2 store
    function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] waddr, input logic [31:0] alu,
                                input int kind, input bit b, input bit h, input bit u,
                                input bit exc, input bit ertn, input logic [31:0] rdata);
        ins_t i;
        i.pc = pc; i.waddr = waddr; i.alu = alu; i.rf_we = (kind != 2);
        i.mreq = (kind != 0); i.load = (kind == 1);
        i.b = b; i.h = h; i.u = u; i.exc = exc; i.ertn = ertn; i.rdata = rdata;
        i.id = next_id++;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        int sz;
        bit exc;
        sz  = $urandom_range(0, 2);
        exc = ($urandom_range(0, 7) == 0);
        return mk($urandom, 5'($urandom), $urandom, $urandom_range(0, 2), sz == 0, sz == 1,
                  1'($urandom), exc, !exc && $urandom_range(0, 15) == 0, $urandom);
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (resp_q[k]) if (!(cur_v && resp_q[k].id == cur.id)) n++;
        return n;
    endfunction

    task automatic step(input bit offer, input bit wb, input bit dok_req, input bit fl_req);
        bit    ev, dok, fl, hit, rdy, alw, fwe, busy;
        int    st, after;
        ins_t  e;
        resp_t r;
        @(posedge clk); #1;
        dok   = dok_req && resp_q.size() > 0;
        hit   = dok && cur_v && resp_q[0].id == cur.id;
        st    = stale_cnt();
        after = st - ((dok && !hit) ? 1 : 0) + ((cur_v && cur.mreq && !cur_done && !hit) ? 1 : 0);
        fl    = fl_req && after <= 1;
        ev    = offer && ex_q.size() > 0 && !fl;
        e     = ev ? ex_q[0] : rnd_ins();
        bus.ex_to_mem_valid   = ev;
        bus.in_pc             = e.pc;
        bus.in_rf_we          = e.rf_we;
        bus.in_rf_waddr       = e.waddr;
        bus.in_alu_result     = e.alu;
        bus.in_mem_req        = e.mreq;
        bus.in_res_from_mem   = e.load;
        bus.in_ld_b           = e.b;
        bus.in_ld_h           = e.h;
        bus.in_ld_u           = e.u;
        bus.in_excep_en       = e.exc;
        bus.in_ertn           = e.ertn;
        bus.wb_allowin        = wb;
        bus.flush             = fl;
        bus.data_sram_data_ok = dok;
        bus.data_sram_rdata   = dok ? resp_q[0].rdata : $urandom;
        @(negedge clk);
        rdy = cur_v && (!cur.mreq || cur_done || hit);
        alw = !cur_v || (rdy && wb);
        chk("allowin", bus.mem_allowin, alw);
        chk("wb_valid", bus.mem_to_wb_valid, rdy);
        if (rdy) begin
            chk("out_pc", bus.out_pc, cur.pc);
            chk("out_rf_we", bus.out_rf_we, cur.rf_we && !cur.exc);
            chk("out_waddr", bus.out_rf_waddr, cur.waddr);
            chk("out_wdata", bus.out_rf_wdata, wdata_of(cur));
            chk("out_excep", bus.out_excep_en, cur.exc);
            chk("out_ertn", bus.out_ertn, cur.ertn);
        end
        chk("ex_bus", bus.mem_to_ex_bus, {30'b0, cur_v && cur.exc, cur_v && cur.ertn});
        fwe = cur_v && cur.rf_we && !cur.exc;
`ifdef MEM_LOAD_FWD_EN
        busy = cur_v && cur.load && !rdy;
`else
        busy = cur_v && cur.load;
`endif
        chk("fwd_we", bus.mem_fwd_we, fwe);
        chk("fwd_busy", bus.mem_fwd_busy, busy);
        if (fwe) chk("fwd_waddr", bus.mem_fwd_waddr, cur.waddr);
        if (fwe && !busy) chk("fwd_wdata", bus.mem_fwd_wdata, wdata_of(cur));
        chk("cancel_cnt", 32'(dut.cancel_cnt), st);
        if (dok) void'(resp_q.pop_front());
        if (hit) cur_done = 1;
        if (fl) cur_v = 0;
        else if (alw) begin
            cur_v = ev;
            if (ev) begin
                cur = ex_q.pop_front();
                cur_done = 0;
                if (cur.mreq) begin
                    r.id = cur.id;
                    r.rdata = cur.rdata;
                    resp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_allowin"}, bus.mem_allowin, 1);
        chk({tag, "_valid"}, bus.mem_to_wb_valid, 0);
        chk({tag, "_pc"}, bus.out_pc, 0);
        chk({tag, "_wdata"}, bus.out_rf_wdata, 0);
        chk({tag, "_exbus"}, bus.mem_to_ex_bus, 0);
        chk({tag, "_fwd_we"}, bus.mem_fwd_we, 0);
        chk({tag, "_busy"}, bus.mem_fwd_busy, 0);
        chk({tag, "_cnt"}, 32'(dut.cancel_cnt), 0);
    endtask

    initial begin
        bus.ex_to_mem_valid = 0; bus.in_pc = 0; bus.in_rf_we = 0; bus.in_rf_waddr = 0;
        bus.in_alu_result = 0; bus.in_mem_req = 0; bus.in_res_from_mem = 0; bus.in_ld_b = 0;
        bus.in_ld_h = 0; bus.in_ld_u = 0; bus.in_excep_en = 0; bus.in_ertn = 0;
        bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0; bus.flush = 0; bus.wb_allowin = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        resetn = 1;

        // ld.b with a delayed response
        ex_q.push_back(mk(32'h100, 5'd3, 32'h1003, 1, 1, 0, 0, 0, 0, 32'h80112233));
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("ldb_wait_valid", bus.mem_to_wb_valid, 0);
        chk("ldb_wait_busy", bus.mem_fwd_busy, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("ldb_valid", bus.mem_to_wb_valid, 1);
        chk("ldb_wdata", bus.out_rf_wdata, 32'hFFFFFF80);
`ifdef MEM_LOAD_FWD_EN
        chk("ldb_busy_dok", bus.mem_fwd_busy, 0);
        chk("ldb_fwd_data", bus.mem_fwd_wdata, 32'hFFFFFF80);
`else
        chk("ldb_busy_dok", bus.mem_fwd_busy, 1);
`endif

        // back-to-back ld.hu, ld.w, alu with immediate responses
        ex_q.push_back(mk(32'h200, 5'd4, 32'h2002, 1, 0, 1, 1, 0, 0, 32'h9ABC1234));
        ex_q.push_back(mk(32'h204, 5'd5, 32'h2000, 1, 0, 0, 0, 0, 0, 32'h9ABC1234));
        ex_q.push_back(mk(32'h208, 5'd6, 32'h55, 0, 0, 0, 0, 0, 0, 0));
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("ldhu_wdata", bus.out_rf_wdata, 32'h00009ABC);
        chk("ldhu_allowin", bus.mem_allowin, 1);
        step(1, 1, 1, 0);
        chk("ldw_wdata", bus.out_rf_wdata, 32'h9ABC1234);
        step(0, 1, 0, 0);
        chk("alu_valid", bus.mem_to_wb_valid, 1);
        chk("alu_wdata", bus.out_rf_wdata, 32'h55);

        // response arrives while WB stalls
        ex_q.push_back(mk(32'h300, 5'd7, 32'h3000, 1, 0, 0, 0, 0, 0, 32'h13572468));
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        chk("stall_wdata0", bus.out_rf_wdata, 32'h13572468);
        repeat (2) begin
            step(0, 0, 0, 0);
            chk("stall_hold_valid", bus.mem_to_wb_valid, 1);
            chk("stall_hold_wdata", bus.out_rf_wdata, 32'h13572468);
        end
        step(0, 1, 0, 0);
        chk("stall_go", bus.mem_allowin, 1);

        // flush with a pending load, then the stale response is dropped
        ex_q.push_back(mk(32'h400, 5'd8, 32'h4000, 1, 0, 0, 0, 0, 0, 32'h0000DEAD));
        ex_q.push_back(mk(32'h404, 5'd9, 32'h4100, 1, 0, 1, 1, 0, 0, 32'h0000BEEF));
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(1, 1, 0, 0);
        chk("flush_cnt", 32'(dut.cancel_cnt), 1);
        chk("flush_valid", bus.mem_to_wb_valid, 0);
        step(0, 1, 1, 0);
        chk("drop_valid", bus.mem_to_wb_valid, 0);
        step(0, 1, 1, 0);
        chk("beef_valid", bus.mem_to_wb_valid, 1);
        chk("beef_wdata", bus.out_rf_wdata, 32'h0000BEEF);

        // exception squashes rf_we
        ex_q.push_back(mk(32'h500, 5'd10, 32'h77, 0, 0, 0, 0, 1, 0, 0));
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("exc_rf_we", bus.out_rf_we, 0);
        chk("exc_bus", bus.mem_to_ex_bus, 2'b10);
        step(0, 1, 0, 0);

        // reset in the middle of a stalled load with a cancel pending
        ex_q.push_back(mk(32'h600, 5'd11, 32'h6000, 1, 0, 0, 0, 0, 0, 32'h1));
        ex_q.push_back(mk(32'h604, 5'd12, 32'h6004, 1, 0, 0, 0, 0, 0, 32'h2));
        step(1, 1, 0, 0);
        step(0, 1, 0, 1);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_reset_cnt", 32'(dut.cancel_cnt), 1);
        @(posedge clk); #1;
        resetn = 0;
        bus.ex_to_mem_valid = 0; bus.flush = 0; bus.data_sram_data_ok = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("midreset");
        resetn = 1;
        cur_v = 0;
        resp_q.delete();
        ex_q.delete();

        for (int n = 0; n < 4000; n++) begin
            if (ex_q.size() < 4) ex_q.push_back(rnd_ins());
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0);
        end
        repeat (20) step(0, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
